// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/forward control with boot bubbles and memory-wait watchdog.
// Define HAZARD_FORWARD_EN for forwarding + load-use; otherwise a full RAW interlock.
module hazard_ctrl #(
    parameter int BOOT_CYCLES = 2,
    parameter int MEM_TIMEOUT = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] Rs1D,
    input  logic [4:0] Rs2D,
    input  logic [4:0] Rs1E,
    input  logic [4:0] Rs2E,
    input  logic [4:0] RdE,
    input  logic [4:0] RdM,
    input  logic [4:0] RdW,
    input  logic       RegWriteE,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    input  logic       ResultSrcE0,
    input  logic       PCSrcE,
    input  logic       MemReqM,
    input  logic       MemRdyM,
    output logic       StallF,
    output logic       StallD,
    output logic       StallE,
    output logic       StallM,
    output logic       FlushD,
    output logic       FlushE,
    output logic       FlushW,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       busy,
    output logic       memErr
);

    localparam int WW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES - 1);
    localparam logic [WW-1:0] WAIT_MAX = WW'(MEM_TIMEOUT);

    typedef enum logic [1:0] {BOOT, RUN, MWAIT} state_t;

    state_t        state, state_nxt;
    logic [3:0]    boot_cnt, boot_nxt;
    logic [WW-1:0] wait_cnt, wait_nxt;
    logic          mem_err, err_nxt;

    logic          data_hz;
    logic [1:0]    fwd_a, fwd_b;
    logic          hold_pipe, run_ok;

`ifdef HAZARD_FORWARD_EN
    logic m_a, m_b, w_a, w_b;

    assign m_a = RegWriteM && (RdM != 5'd0) && (RdM == Rs1E);
    assign m_b = RegWriteM && (RdM != 5'd0) && (RdM == Rs2E);
    assign w_a = RegWriteW && (RdW != 5'd0) && (RdW == Rs1E);
    assign w_b = RegWriteW && (RdW != 5'd0) && (RdW == Rs2E);

    assign fwd_a = m_a ? 2'b10 : (w_a ? 2'b01 : 2'b00);
    assign fwd_b = m_b ? 2'b10 : (w_b ? 2'b01 : 2'b00);

    assign data_hz = ResultSrcE0 && RegWriteE && (RdE != 5'd0) &&
                     ((RdE == Rs1D) || (RdE == Rs2D));
`else
    logic raw1, raw2;
    logic unused_fwd;

    // W is not checked: the register file writes before it reads.
    assign raw1 = (Rs1D != 5'd0) &&
                  ((RegWriteE && (RdE == Rs1D)) ||
                   (RegWriteM && (RdM == Rs1D)));
    assign raw2 = (Rs2D != 5'd0) &&
                  ((RegWriteE && (RdE == Rs2D)) ||
                   (RegWriteM && (RdM == Rs2D)));

    assign data_hz = raw1 || raw2;
    assign fwd_a = 2'b00;
    assign fwd_b = 2'b00;
    assign unused_fwd = ^{Rs1E, Rs2E, RdW, RegWriteW, ResultSrcE0};
`endif

    always_comb begin
        state_nxt = state;
        boot_nxt  = boot_cnt;
        wait_nxt  = wait_cnt;
        err_nxt   = mem_err;
        hold_pipe = 1'b0;
        run_ok    = 1'b0;
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        StallM    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        FlushW    = 1'b0;
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;

        unique case (state)
            BOOT: begin
                StallF = 1'b1;
                FlushD = 1'b1;
                FlushE = 1'b1;
                if (boot_cnt == BOOT_LAST) begin
                    state_nxt = RUN;
                    boot_nxt  = 4'd0;
                end else begin
                    boot_nxt = boot_cnt + 4'd1;
                end
            end
            RUN: begin
                ForwardAE = fwd_a;
                ForwardBE = fwd_b;
                if (MemReqM && !MemRdyM) begin
                    hold_pipe = 1'b1;
                    state_nxt = MWAIT;
                    wait_nxt  = WW'(1);
                end else begin
                    run_ok = 1'b1;
                end
            end
            MWAIT: begin
                ForwardAE = fwd_a;
                ForwardBE = fwd_b;
                if (MemRdyM || (wait_cnt == WAIT_MAX)) begin
                    run_ok    = 1'b1;
                    state_nxt = RUN;
                    wait_nxt  = '0;
                    if (!MemRdyM)
                        err_nxt = 1'b1;
                end else begin
                    hold_pipe = 1'b1;
                    if (wait_cnt != {WW{1'b1}})
                        wait_nxt = wait_cnt + 1'b1;
                end
            end
            default: state_nxt = BOOT;
        endcase

        if (hold_pipe) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
        end

        // A taken branch squashes the stalled instruction anyway.
        if (run_ok) begin
            StallF = data_hz && !PCSrcE;
            StallD = data_hz && !PCSrcE;
            FlushD = PCSrcE;
            FlushE = PCSrcE || data_hz;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= BOOT;
            boot_cnt <= 4'd0;
            wait_cnt <= '0;
            mem_err  <= 1'b0;
        end else begin
            state    <= state_nxt;
            boot_cnt <= boot_nxt;
            wait_cnt <= wait_nxt;
            mem_err  <= err_nxt;
        end
    end

    assign busy   = (state != RUN);
    assign memErr = mem_err;

endmodule
